bht_access_arbiter: RTL and testbench
=====================================

Name: bht_access_arbiter

Overview:
- Shares the single-ported BHT (M=32 entries, N=2-bit counters, 9-bit PC) between a fetch-side lookup requester and a resolve-side update requester.
- Grants one BHT access per cycle.
- Buffers branch resolutions in an update queue and bounds update starvation with a counter.
- Sits between the fetch/resolve stages and the BHT instance.

Parameters:
PC_W, 9, PC bits presented to the BHT index.
Q_DEPTH, 4, update queue depth; power of two, ≥2.
STARVE_MAX, 3, consecutive lookup grants allowed while the queue is non-empty before an update is forced.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset.
lk_valid  in  1  lookup request.
lk_pc  in  PC_W  lookup PC.
lk_ready  out  1  lookup granted this cycle.
lk_pred_valid  out  1  prediction for the lookup granted in the previous cycle.
lk_pred  out  1  predicted taken.
up_valid  in  1  resolved branch.
up_pc  in  PC_W  resolved PC.
up_taken  in  1  actual outcome.
up_ready  out  1  queue accepts the update this cycle.
bht_en  out  1  BHT access this cycle.
bht_we  out  1  1 = update access, 0 = lookup access.
bht_pc  out  PC_W  BHT index PC.
bht_taken  out  1  outcome for update access.
bht_prediction  in  1  BHT read data, valid one cycle after a lookup access.

Behaviour:
- Reset (reset==0 at posedge):
  - Queue emptied; starve_cnt=0; grant FSM to IDLE.
  - lk_pred_valid=0, lk_pred=0.
  - Combinational outputs are driven from the reset state, so bht_en=0 and lk_ready=0 while reset is held.
  - Reset mid-operation discards queued updates and any in-flight prediction.
- Update queue: FIFO of {pc, taken}, Q_DEPTH entries.
  - Pointers are log2(Q_DEPTH)+1 bits wide; they wrap modulo 2*Q_DEPTH.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
- Grant decision is combinational from current state and inputs:
  - upd_win = !empty && (!lk_valid || starve_cnt==STARVE_MAX || full).
  - If upd_win: bht_en=1, bht_we=1, bht_pc/bht_taken = queue head; pop at clock edge.
  - Else if lk_valid: bht_en=1, bht_we=0, bht_pc=lk_pc, lk_ready=1.
  - Else: bht_en=0, bht_we=0, bht_pc=0.
- up_ready = !full || upd_win. Push and pop in the same cycle are allowed at any occupancy; occupancy is then unchanged.
- An update pushed this cycle becomes eligible for BHT access at the earliest next cycle; there is no bypass.
- starve_cnt:
  - Set to 0 when upd_win or the queue is empty.
  - Increments (saturating at STARVE_MAX) when a lookup is granted while the queue is non-empty.
- Grant FSM (registered): IDLE, LOOKUP, UPDATE; next state reflects this cycle's grant.
- In state LOOKUP: lk_pred_valid=1 and lk_pred=bht_prediction. Otherwise lk_pred_valid=0 and lk_pred holds 0.
- Lookup latency is 1 cycle from grant to prediction; back-to-back lookups give a prediction every cycle.
- No read-after-write ordering: a lookup may see BHT state from before queued updates are applied.

Optional Feature:
- Macro BHT_ARB_STATS_EN.
- When defined, adds these outputs, all reset to 0 and saturating at all-ones:
  - stat_lookups  out  32: granted lookups.
  - stat_updates  out  32: drained updates.
  - stat_lk_stalls  out  32: cycles with lk_valid && !lk_ready.
  - stat_up_stalls  out  32: cycles with up_valid && !up_ready.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package bht_pkg holds:
  - Constants: BHT_PC_W=9, BHT_ENTRIES=32, BHT_CTR_W=2.
  - Typedef bht_upd_t {pc, taken}.
  - Grant-state enum {GNT_IDLE, GNT_LOOKUP, GNT_UPDATE}.
- One sub-module, bht_upd_fifo: parameterised sync FIFO with push/pop/full/empty/head.
- Arbitration, the starvation counter and the FSM stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with lk_valid=1 and up_valid=1 → bht_en=0, lk_ready=0, lk_pred_valid=0; after release, empty queue, first grant is the lookup.
- Lookup only: lk_pc=0x0A4 on 3 consecutive cycles → bht_pc=0x0A4, bht_we=0 each cycle; lk_pred_valid=1 on cycles 2-4 with lk_pred equal to the BHT model's prediction.
- Update only: push {0x013,1} and {0x1F0,0} with no lookups → drained in order on the next 2 cycles with bht_we=1; queue then empty.
- Starvation: queue holds 1 entry, lk_valid held high → 3 lookups granted, then 1 forced update with lk_ready=0, then lookups resume.
- Full queue: push 4 updates while lookups are continuous → up_ready stays 1 (update forced at full, simultaneous push/pop); with no push on the full cycle, occupancy drops to 3.
- Scoreboard: replay a PC/taken trace through the arbiter plus the BHT against a reference model applying updates in queue order → identical prediction count and correct-prediction count.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared constants and types for the branch history table and its access arbiter.
// The update record and grant states are common to the arbiter and its queue.
package bht_pkg;

  localparam int BHT_PC_W    = 9;
  localparam int BHT_ENTRIES = 32;
  localparam int BHT_CTR_W   = 2;

  typedef struct packed {
    logic [BHT_PC_W-1:0] pc;
    logic                taken;
  } bht_upd_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_LOOKUP,
    GNT_UPDATE
  } gnt_state_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO that holds resolved branches waiting for a BHT write slot.
// Pointers carry one extra wrap bit, so full and empty can be told apart without a counter.
module bht_upd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bht_access_arbiter.sv
// Shares the single BHT port between fetch lookups and queued resolve updates, one access per cycle.
// Define BHT_ARB_STATS_EN to add saturating grant and stall counters.
module bht_access_arbiter
  import bht_pkg::*;
#(
  parameter int PC_W       = BHT_PC_W,
  parameter int Q_DEPTH    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_ready,
  output logic            lk_pred_valid,
  output logic            lk_pred,
  input  logic            up_valid,
  input  logic [PC_W-1:0] up_pc,
  input  logic            up_taken,
  output logic            up_ready,
  output logic            bht_en,
  output logic            bht_we,
  output logic [PC_W-1:0] bht_pc,
  output logic            bht_taken,
  input  logic            bht_prediction
`ifdef BHT_ARB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_lk_stalls,
  output logic [31:0]     stat_up_stalls
`endif
);

  localparam int               SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

  gnt_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic [PC_W:0] q_head;
  logic          upd_win;
  logic          lk_gnt;

  bht_upd_fifo #(
    .WIDTH (PC_W + 1),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({up_pc, up_taken}),
    .pop       (upd_win),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Grants are qualified by reset so the BHT port stays quiet while reset is held.
  always_comb begin
    upd_win   = reset && !q_empty && (!lk_valid || (starve_cnt == STARVE_LIM) || q_full);
    lk_gnt    = reset && lk_valid && !upd_win;
    bht_en    = upd_win || lk_gnt;
    bht_we    = upd_win;
    bht_pc    = '0;
    bht_taken = 1'b0;
    if (upd_win) begin
      bht_pc    = q_head[PC_W:1];
      bht_taken = q_head[0];
    end else if (lk_gnt) begin
      bht_pc = lk_pc;
    end
  end

  assign lk_ready      = lk_gnt;
  assign up_ready      = reset && (!q_full || upd_win);
  assign q_push        = up_valid && up_ready;
  assign lk_pred_valid = (state == GNT_LOOKUP);
  assign lk_pred       = lk_pred_valid && bht_prediction;

  // The state records last cycle's grant, which tells us when BHT read data belongs to the fetch side.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= GNT_IDLE;
    end else if (upd_win) begin
      state <= GNT_UPDATE;
    end else if (lk_gnt) begin
      state <= GNT_LOOKUP;
    end else begin
      state <= GNT_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (upd_win || q_empty) begin
      starve_cnt <= '0;
    end else if (lk_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + {{(SW-1){1'b0}}, 1'b1};
    end
  end

`ifdef BHT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_lookups   <= '0;
      stat_updates   <= '0;
      stat_lk_stalls <= '0;
      stat_up_stalls <= '0;
    end else begin
      if (lk_gnt && (stat_lookups != '1))
        stat_lookups <= stat_lookups + 32'd1;
      if (upd_win && (stat_updates != '1))
        stat_updates <= stat_updates + 32'd1;
      if (lk_valid && !lk_ready && (stat_lk_stalls != '1))
        stat_lk_stalls <= stat_lk_stalls + 32'd1;
      if (up_valid && !up_ready && (stat_up_stalls != '1))
        stat_up_stalls <= stat_up_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bht_access_arbiter.sv
// Self-checking bench for bht_access_arbiter with a behavioural 2-bit BHT behind it.
// Update order is tracked in a scoreboard queue and predictions against a reference counter table.
module tb_bht_access_arbiter;
  import bht_pkg::*;

  localparam int PC_W = BHT_PC_W;
  localparam int N_TR = 40;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            lk_valid = 1'b0;
  logic [PC_W-1:0] lk_pc = '0;
  logic            lk_ready;
  logic            lk_pred_valid;
  logic            lk_pred;
  logic            up_valid = 1'b0;
  logic [PC_W-1:0] up_pc = '0;
  logic            up_taken = 1'b0;
  logic            up_ready;
  logic            bht_en;
  logic            bht_we;
  logic [PC_W-1:0] bht_pc;
  logic            bht_taken;
  logic            bht_prediction;

  logic [1:0] bht_mem [BHT_ENTRIES];
  logic [1:0] ref_ctr [BHT_ENTRIES];
  bht_upd_t   upq[$];
  int         checks = 0;
  int         passes = 0;

  bht_access_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .lk_valid       (lk_valid),
    .lk_pc          (lk_pc),
    .lk_ready       (lk_ready),
    .lk_pred_valid  (lk_pred_valid),
    .lk_pred        (lk_pred),
    .up_valid       (up_valid),
    .up_pc          (up_pc),
    .up_taken       (up_taken),
    .up_ready       (up_ready),
    .bht_en         (bht_en),
    .bht_we         (bht_we),
    .bht_pc         (bht_pc),
    .bht_taken      (bht_taken),
    .bht_prediction (bht_prediction)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] init_ctr(input int i);
    return 2'((i * 7 + 2) % 4);
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Behavioural BHT: registered read data, counter write on update access.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_mem[i] <= init_ctr(i);
      bht_prediction <= 1'b0;
    end else if (bht_en) begin
      if (bht_we) bht_mem[bht_pc[4:0]] <= sat(bht_mem[bht_pc[4:0]], bht_taken);
      else        bht_prediction <= bht_mem[bht_pc[4:0]][1];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ref_apply(input logic [PC_W-1:0] pc, input logic t);
    ref_ctr[pc[4:0]] = sat(ref_ctr[pc[4:0]], t);
  endtask

  task automatic test_reset;
    logic e;
    reset = 1'b0; lk_valid = 1'b1; lk_pc = 9'h155;
    up_valid = 1'b1; up_pc = 9'h0AA; up_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bht_en !== 1'b0) $display("[TB] FAIL rst_bht_en got %0b exp 0", bht_en); else passes++;
      checks++; if (lk_ready !== 1'b0) $display("[TB] FAIL rst_lk_ready got %0b exp 0", lk_ready); else passes++;
      checks++; if (lk_pred_valid !== 1'b0) $display("[TB] FAIL rst_pred_valid got %0b exp 0", lk_pred_valid); else passes++;
      tick();
    end
    reset = 1'b1; up_valid = 1'b0; lk_pc = 9'h055;
    @(negedge clk);
    checks++; if (lk_ready !== 1'b1) $display("[TB] FAIL rel_lk_ready got %0b exp 1", lk_ready); else passes++;
    checks++; if (bht_we !== 1'b0) $display("[TB] FAIL rel_bht_we got %0b exp 0", bht_we); else passes++;
    checks++; if (bht_pc !== 9'h055) $display("[TB] FAIL rel_bht_pc got %0h exp 055", bht_pc); else passes++;
    checks++; if (up_ready !== 1'b1) $display("[TB] FAIL rel_up_ready got %0b exp 1", up_ready); else passes++;
    tick();
    lk_valid = 1'b0;
    e = ref_ctr[5'd21][1];
    @(negedge clk);
    checks++; if (bht_en !== 1'b0) $display("[TB] FAIL rel_empty_q bht_en got %0b exp 0", bht_en); else passes++;
    checks++; if (lk_pred_valid !== 1'b1) $display("[TB] FAIL rel_pred_valid got %0b exp 1", lk_pred_valid); else passes++;
    checks++; if (lk_pred !== e) $display("[TB] FAIL rel_pred got %0b exp %0b", lk_pred, e); else passes++;
    tick();
  endtask

  task automatic test_lookup;
    logic e;
    e = ref_ctr[5'd4][1];
    lk_pc = 9'h0A4;
    for (int i = 0; i < 4; i++) begin
      lk_valid = (i < 3);
      @(negedge clk);
      if (i < 3) begin
        checks++; if (bht_pc !== 9'h0A4) $display("[TB] FAIL lk_bht_pc got %0h exp 0a4", bht_pc); else passes++;
        checks++; if (bht_we !== 1'b0 || bht_en !== 1'b1) $display("[TB] FAIL lk_access en/we got %0b/%0b exp 1/0", bht_en, bht_we); else passes++;
      end
      if (i > 0) begin
        checks++; if (lk_pred_valid !== 1'b1) $display("[TB] FAIL lk_pred_valid c%0d got %0b exp 1", i, lk_pred_valid); else passes++;
        checks++; if (lk_pred !== e) $display("[TB] FAIL lk_pred c%0d got %0b exp %0b", i, lk_pred, e); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_update;
    lk_valid = 1'b0;
    up_valid = 1'b1; up_pc = 9'h013; up_taken = 1'b1;
    @(negedge clk);
    checks++; if (up_ready !== 1'b1) $display("[TB] FAIL up_ready got %0b exp 1", up_ready); else passes++;
    checks++; if (bht_en !== 1'b0) $display("[TB] FAIL up_no_bypass bht_en got %0b exp 0", bht_en); else passes++;
    tick();
    up_pc = 9'h1F0; up_taken = 1'b0;
    @(negedge clk);
    checks++; if (bht_we !== 1'b1 || bht_pc !== 9'h013 || bht_taken !== 1'b1)
      $display("[TB] FAIL up_first got we=%0b pc=%0h t=%0b exp we=1 pc=013 t=1", bht_we, bht_pc, bht_taken); else passes++;
    ref_apply(9'h013, 1'b1);
    tick();
    up_valid = 1'b0;
    @(negedge clk);
    checks++; if (bht_we !== 1'b1 || bht_pc !== 9'h1F0 || bht_taken !== 1'b0)
      $display("[TB] FAIL up_second got we=%0b pc=%0h t=%0b exp we=1 pc=1f0 t=0", bht_we, bht_pc, bht_taken); else passes++;
    ref_apply(9'h1F0, 1'b0);
    tick();
    @(negedge clk);
    checks++; if (bht_en !== 1'b0) $display("[TB] FAIL up_drained bht_en got %0b exp 0", bht_en); else passes++;
    tick();
  endtask

  task automatic test_starvation;
    lk_valid = 1'b1; lk_pc = 9'h021;
    up_pc = 9'h0C5; up_taken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_valid = (i == 0);
      @(negedge clk);
      if (i < 4) begin
        checks++; if (lk_ready !== 1'b1 || bht_we !== 1'b0) $display("[TB] FAIL starve_lk c%0d got rdy=%0b we=%0b exp 1/0", i, lk_ready, bht_we); else passes++;
      end else if (i == 4) begin
        checks++; if (lk_ready !== 1'b0 || bht_we !== 1'b1 || bht_pc !== 9'h0C5 || bht_taken !== 1'b1)
          $display("[TB] FAIL starve_force got rdy=%0b we=%0b pc=%0h exp 0/1/0c5", lk_ready, bht_we, bht_pc); else passes++;
        ref_apply(9'h0C5, 1'b1);
      end else begin
        checks++; if (lk_ready !== 1'b1) $display("[TB] FAIL starve_resume got %0b exp 1", lk_ready); else passes++;
        checks++; if (lk_pred_valid !== 1'b0) $display("[TB] FAIL starve_pred_valid got %0b exp 0", lk_pred_valid); else passes++;
      end
      tick();
    end
    lk_valid = 1'b0;
    tick();
  endtask

  task automatic test_full_queue(input logic push_on_full);
    bht_upd_t u;
    int drained;
    lk_valid = 1'b1; lk_pc = 9'h0E7;
    for (int k = 0; k < 4; k++) begin
      up_valid = 1'b1; up_pc = 9'(9'h100 + k); up_taken = k[0];
      u.pc = up_pc; u.taken = up_taken; upq.push_back(u);
      @(negedge clk);
      checks++; if (up_ready !== 1'b1 || lk_ready !== 1'b1) $display("[TB] FAIL fill c%0d got up_rdy=%0b lk_rdy=%0b exp 1/1", k, up_ready, lk_ready); else passes++;
      tick();
    end
    up_valid = push_on_full; up_pc = 9'h1AA; up_taken = 1'b1;
    if (push_on_full) begin u.pc = up_pc; u.taken = up_taken; upq.push_back(u); end
    u = upq.pop_front();
    @(negedge clk);
    checks++; if (up_ready !== 1'b1 || lk_ready !== 1'b0) $display("[TB] FAIL full_grant got up_rdy=%0b lk_rdy=%0b exp 1/0", up_ready, lk_ready); else passes++;
    checks++; if (bht_we !== 1'b1 || bht_pc !== u.pc || bht_taken !== u.taken)
      $display("[TB] FAIL full_head got we=%0b pc=%0h t=%0b exp we=1 pc=%0h t=%0b", bht_we, bht_pc, bht_taken, u.pc, u.taken); else passes++;
    ref_apply(u.pc, u.taken);
    tick();
    lk_valid = 1'b0; up_valid = 1'b0;
    drained = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bht_en && bht_we) begin
        drained++;
        checks++;
        if (upq.size() == 0) $display("[TB] FAIL full_drain extra update pc=%0h", bht_pc);
        else begin
          u = upq.pop_front();
          if (bht_pc !== u.pc || bht_taken !== u.taken) $display("[TB] FAIL full_drain got pc=%0h t=%0b exp pc=%0h t=%0b", bht_pc, bht_taken, u.pc, u.taken);
          else passes++;
          ref_apply(u.pc, u.taken);
        end
      end
      tick();
    end
    checks++; if (drained != (push_on_full ? 4 : 3)) $display("[TB] FAIL full_occupancy got %0d exp %0d", drained, push_on_full ? 4 : 3); else passes++;
    upq.delete();
  endtask

  task automatic test_scoreboard;
    logic [PC_W-1:0] tr_pc [N_TR];
    logic            tr_tk [N_TR];
    int              pidx_q[$];
    logic            pred_q[$];
    int              res_q[$];
    bht_upd_t        u;
    logic            e;
    int              idx, li, k;
    int              dut_preds, dut_correct, ref_preds, ref_correct;
    li = 0; dut_preds = 0; dut_correct = 0; ref_preds = 0; ref_correct = 0;
    for (int i = 0; i < N_TR; i++) begin
      tr_pc[i] = 9'(9'h010 + 37 * $urandom_range(0, 5));
      tr_tk[i] = ($urandom_range(0, 3) != 0) ^ tr_pc[i][2];
    end
    for (int c = 0; c < 600; c++) begin
      if (li == N_TR && res_q.size() == 0 && upq.size() == 0 && pidx_q.size() == 0) break;
      lk_valid = (li < N_TR);
      lk_pc    = (li < N_TR) ? tr_pc[li] : '0;
      up_valid = (res_q.size() > 0);
      if (up_valid) begin up_pc = tr_pc[res_q[0]]; up_taken = tr_tk[res_q[0]]; end
      @(negedge clk);
      if (bht_en && bht_we) begin
        checks++;
        if (upq.size() == 0) $display("[TB] FAIL sb_update unexpected pc=%0h", bht_pc);
        else begin
          u = upq.pop_front();
          if (bht_pc !== u.pc || bht_taken !== u.taken) $display("[TB] FAIL sb_update got pc=%0h t=%0b exp pc=%0h t=%0b", bht_pc, bht_taken, u.pc, u.taken);
          else passes++;
          ref_apply(u.pc, u.taken);
        end
      end
      if (up_valid && up_ready) begin
        k = res_q.pop_front();
        u.pc = tr_pc[k]; u.taken = tr_tk[k];
        upq.push_back(u);
      end
      if (lk_pred_valid) begin
        checks++;
        if (pidx_q.size() == 0) $display("[TB] FAIL sb_pred unexpected prediction %0b", lk_pred);
        else begin
          idx = pidx_q.pop_front();
          e = pred_q.pop_front();
          if (lk_pred !== e) $display("[TB] FAIL sb_pred idx%0d got %0b exp %0b", idx, lk_pred, e);
          else passes++;
          dut_preds++;
          if (lk_pred == tr_tk[idx]) dut_correct++;
          res_q.push_back(idx);
        end
      end
      if (lk_ready) begin
        e = ref_ctr[lk_pc[4:0]][1];
        pidx_q.push_back(li); pred_q.push_back(e);
        ref_preds++;
        if (e == tr_tk[li]) ref_correct++;
        li++;
      end
      tick();
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    checks++; if (ref_preds != N_TR) $display("[TB] FAIL sb_lookups got %0d exp %0d", ref_preds, N_TR); else passes++;
    checks++; if (dut_preds != ref_preds) $display("[TB] FAIL sb_pred_count got %0d exp %0d", dut_preds, ref_preds); else passes++;
    checks++; if (dut_correct != ref_correct) $display("[TB] FAIL sb_correct_count got %0d exp %0d", dut_correct, ref_correct); else passes++;
    checks++; if (upq.size() != 0 || res_q.size() != 0) $display("[TB] FAIL sb_drain got upq=%0d res=%0d exp 0/0", upq.size(), res_q.size()); else passes++;
  endtask

  initial begin
    for (int i = 0; i < BHT_ENTRIES; i++) ref_ctr[i] = init_ctr(i);
    test_reset();
    test_lookup();
    test_update();
    test_starvation();
    test_full_queue(1'b0);
    test_full_queue(1'b1);
    test_scoreboard();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
